// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory controller.
package mem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Widest latency down-counter needed for LATENCY in 1..15.
  localparam int unsigned CNT_WIDTH = 4;

endpackage

// File: rtl/main_mem_ctrl_req_fifo.sv
// Two-entry synchronous request FIFO; push and pop at the same edge is legal even when full.
module req_fifo #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] store [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             push_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = store[rd_ptr];
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push_ok) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory stage: in-order servicing of queued cache requests with a fixed access latency.
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ce_in,
  input  logic               rw_in,
  input  logic [A_WIDTH-1:0] addr_in,
  input  logic [D_WIDTH-1:0] wdata_in,
  output logic [D_WIDTH-1:0] rdata_out,
  output logic               rdv,
  output logic               busy,
  output logic               ovf
);

  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic               rw;
    logic [D_WIDTH-1:0] data;
  } req_t;

  localparam int unsigned          REQ_W    = $bits(req_t);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  req_t                 cur;
  req_t                 in_req;
  req_t                 head;
  logic [D_WIDTH-1:0]   mem [1 << A_WIDTH];

  logic       completing;
  logic       ready;
  logic       q_pop;
  logic       q_push;
  logic       bypass;
  logic       q_full;
  logic       q_empty;
  logic [1:0] q_count;

  assign in_req = '{addr: addr_in, rw: rw_in, data: wdata_in};

  // A completing access frees the unit in the same edge, so a new request can start with no gap.
  assign completing = (state == ACCESS) && (cnt == '0);
  assign ready      = (state == IDLE) || completing;
  assign q_pop      = !q_empty && ready;
  assign bypass     = ce_in && q_empty && ready;
  assign q_push     = ce_in && !bypass && (!q_full || q_pop);
  assign busy       = (state == ACCESS) || (q_count != 2'd0);

  req_fifo #(
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (q_push),
    .pop   (q_pop),
    .din   (in_req),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= '0;
      rdata_out <= '0;
      rdv       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rdv <= 1'b0;
      ovf <= ce_in && !bypass && q_full && !q_pop;
      if (completing && (cur.rw == RW_READ)) begin
        rdata_out <= mem[cur.addr];
        rdv       <= 1'b1;
      end
      if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end else if (q_pop) begin
        cur   <= head;
        cnt   <= CNT_LOAD;
        state <= ACCESS;
      end else if (bypass) begin
        cur   <= in_req;
        cnt   <= CNT_LOAD;
        state <= ACCESS;
      end else begin
        state <= IDLE;
      end
    end
  end

  // The array is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!clr && completing && (cur.rw == RW_WRITE)) mem[cur.addr] <= cur.data;
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl with LATENCY=4 and LATENCY=1 instances sharing the stimulus.
module tb_main_mem_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       ce;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rd4, rd1;
  logic       rdv4, busy4, ovf4;
  logic       rdv1, busy1, ovf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  main_mem_ctrl #(.D_WIDTH(8), .A_WIDTH(8), .LATENCY(4)) dut4 (
    .clk(clk), .clr(clr), .ce_in(ce), .rw_in(rw), .addr_in(addr), .wdata_in(wdata),
    .rdata_out(rd4), .rdv(rdv4), .busy(busy4), .ovf(ovf4)
  );

  main_mem_ctrl #(.D_WIDTH(8), .A_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .clr(clr), .ce_in(ce), .rw_in(rw), .addr_in(addr), .wdata_in(wdata),
    .rdata_out(rd1), .rdv(rdv1), .busy(busy1), .ovf(ovf1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic r, input logic [7:0] a, input logic [7:0] d);
    ce = c; rw = r; addr = a; wdata = d;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) step();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, d);
    step();
    idle(6);
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b0;
    step(); step();
    n_checks++; if (rd4 !== 8'h00) begin n_fail++; $display("FAIL reset rdata4 got=%h exp=00", rd4); end
    n_checks++; if (rdv4 !== 1'b0) begin n_fail++; $display("FAIL reset rdv4 got=%b exp=0", rdv4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset busy4 got=%b exp=0", busy4); end
    n_checks++; if (ovf4 !== 1'b0) begin n_fail++; $display("FAIL reset ovf4 got=%b exp=0", ovf4); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset busy1 got=%b exp=0", busy1); end
    clr = 1'b0;
  endtask

  task automatic test_write_read();
    for (int e = 0; e <= 10; e++) begin
      logic eb, er;
      if (e == 0)      drive(1'b1, 1'b0, 8'h10, 8'hA5);
      else if (e == 5) drive(1'b1, 1'b1, 8'h10, 8'h00);
      else             ce = 1'b0;
      step();
      eb = (e < 4) || (e >= 5 && e < 9);
      er = (e == 9);
      n_checks++; if (busy4 !== eb) begin n_fail++; $display("FAIL wr_rd busy e=%0d got=%b exp=%b", e, busy4, eb); end
      n_checks++; if (rdv4 !== er) begin n_fail++; $display("FAIL wr_rd rdv e=%0d got=%b exp=%b", e, rdv4, er); end
      if (e >= 9) begin
        n_checks++; if (rd4 !== 8'hA5) begin n_fail++; $display("FAIL wr_rd rdata e=%0d got=%h exp=a5", e, rd4); end
      end
    end
  endtask

  task automatic test_cache_miss();
    preload(8'h40, 8'h77);
    for (int e = 0; e <= 10; e++) begin
      logic eb, er;
      if (e == 0)      drive(1'b1, 1'b0, 8'h20, 8'h3C);
      else if (e == 1) drive(1'b1, 1'b1, 8'h40, 8'h00);
      else             ce = 1'b0;
      step();
      eb = (e < 8);
      er = (e == 8);
      n_checks++; if (ovf4 !== 1'b0) begin n_fail++; $display("FAIL miss ovf e=%0d got=%b exp=0", e, ovf4); end
      n_checks++; if (busy4 !== eb) begin n_fail++; $display("FAIL miss busy e=%0d got=%b exp=%b", e, busy4, eb); end
      n_checks++; if (rdv4 !== er) begin n_fail++; $display("FAIL miss rdv e=%0d got=%b exp=%b", e, rdv4, er); end
      if (er) begin
        n_checks++; if (rd4 !== 8'h77) begin n_fail++; $display("FAIL miss rdata got=%h exp=77", rd4); end
      end
    end
  endtask

  task automatic test_overflow();
    preload(8'h04, 8'h99);
    for (int e = 0; e <= 13; e++) begin
      logic eb, eo;
      if (e <= 3) drive(1'b1, 1'b0, 8'(e + 1), 8'(17 * (e + 1)));
      else        ce = 1'b0;
      step();
      eb = (e < 12);
      eo = (e == 3);
      n_checks++; if (ovf4 !== eo) begin n_fail++; $display("FAIL ovf pulse e=%0d got=%b exp=%b", e, ovf4, eo); end
      n_checks++; if (busy4 !== eb) begin n_fail++; $display("FAIL ovf busy e=%0d got=%b exp=%b", e, busy4, eb); end
    end
    // Addresses 1..3 hold the accepted writes; 4 still holds its preload because that write was dropped.
    for (int k = 1; k <= 4; k++) begin
      logic       got;
      logic [7:0] data, exp;
      exp = (k < 4) ? 8'(17 * k) : 8'h99;
      drive(1'b1, 1'b1, 8'(k), 8'h00);
      step();
      ce = 1'b0;
      got = 1'b0;
      data = 8'h00;
      for (int i = 0; i < 8; i++) begin
        step();
        if (rdv4) begin got = 1'b1; data = rd4; break; end
      end
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL ovf readback rdv timeout addr=%0d got=0 exp=1", k); end
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL ovf readback addr=%0d got=%h exp=%h", k, data, exp); end
    end
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 4; k++) preload(8'h50 + 8'(k), 8'hA0 + 8'(k));
    for (int e = 0; e <= 17; e++) begin
      logic       er;
      logic [7:0] ed;
      if (e <= 2)      drive(1'b1, 1'b1, 8'h50 + 8'(e), 8'h00);
      else if (e == 4) drive(1'b1, 1'b1, 8'h53, 8'h00);
      else             ce = 1'b0;
      step();
      er = (e == 4) || (e == 8) || (e == 12) || (e == 16);
      ed = 8'hA0 + 8'(e / 4 - 1);
      n_checks++; if (ovf4 !== 1'b0) begin n_fail++; $display("FAIL fullpop ovf e=%0d got=%b exp=0", e, ovf4); end
      n_checks++; if (rdv4 !== er) begin n_fail++; $display("FAIL fullpop rdv e=%0d got=%b exp=%b", e, rdv4, er); end
      if (er) begin
        n_checks++; if (rd4 !== ed) begin n_fail++; $display("FAIL fullpop rdata e=%0d got=%h exp=%h", e, rd4, ed); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       got;
    logic [7:0] data;
    drive(1'b1, 1'b1, 8'h20, 8'h00);
    step();
    ce = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rstmid busy got=%b exp=0", busy4); end
    n_checks++; if (rd4 !== 8'h00) begin n_fail++; $display("FAIL rstmid rdata got=%h exp=00", rd4); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (rdv4 !== 1'b0) begin n_fail++; $display("FAIL rstmid stray rdv i=%0d got=%b exp=0", i, rdv4); end
    end
    drive(1'b1, 1'b1, 8'h20, 8'h00);
    step();
    ce = 1'b0;
    got = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rdv4) begin got = 1'b1; data = rd4; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rstmid readback rdv timeout got=0 exp=1"); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL rstmid readback got=%h exp=3c", data); end
  endtask

  task automatic test_latency1();
    for (int k = 0; k < 3; k++) preload(8'h60 + 8'(k), 8'hC0 + 8'(k));
    for (int e = 0; e <= 4; e++) begin
      logic       er, eb;
      logic [7:0] ed;
      if (e <= 2) drive(1'b1, 1'b1, 8'h60 + 8'(e), 8'h00);
      else        ce = 1'b0;
      step();
      er = (e >= 1) && (e <= 3);
      eb = (e < 3);
      ed = 8'hC0 + 8'(e - 1);
      n_checks++; if (rdv1 !== er) begin n_fail++; $display("FAIL lat1 rdv e=%0d got=%b exp=%b", e, rdv1, er); end
      n_checks++; if (busy1 !== eb) begin n_fail++; $display("FAIL lat1 busy e=%0d got=%b exp=%b", e, busy1, eb); end
      if (er) begin
        n_checks++; if (rd1 !== ed) begin n_fail++; $display("FAIL lat1 rdata e=%0d got=%h exp=%h", e, rd1, ed); end
      end
    end
    idle(10);
  endtask

  initial begin
    clr = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_write_read();
    test_cache_miss();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
